// File: rtl/halve_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : halve_seq
// Brief    : Iterative mod-q halving sequencer, returns x * 2^(-k) mod q.
//            Optional HALVE_SEQ_PIPE_EN: accept a new input on the consume edge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module halve_seq #(
    parameter int LOGQ      = 14,
    parameter int Q_VALUE   = 12289,
    parameter int MAX_SHIFT = 10,
    localparam int SHW      = $clog2(MAX_SHIFT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [LOGQ-1:0] in_data,
    input  logic [SHW-1:0]  in_shift,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGQ-1:0] out_data,
    output logic            busy
);

    localparam logic [LOGQ-1:0] c_half_q    = LOGQ'((Q_VALUE + 1) / 2);
    localparam logic [SHW-1:0]  c_max_shift = SHW'(MAX_SHIFT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LOGQ-1:0]   r_d;
    logic [LOGQ-1:0]   w_d_nxt;
    logic [SHW-1:0]    r_c;
    logic [SHW-1:0]    w_c_nxt;
    logic [LOGQ-1:0]   w_half;
    logic [SHW-1:0]    w_k_eff;
    logic              w_accept;

    // For odd d, (d-1)/2 + (q+1)/2 = (d+q)/2, which stays below q when d < q.
    assign w_half  = {1'b0, r_d[LOGQ-1:1]} + (r_d[0] ? c_half_q : '0);
    assign w_k_eff = (in_shift > c_max_shift) ? c_max_shift : in_shift;

`ifdef HALVE_SEQ_PIPE_EN
    assign in_ready = (r_state == S_IDLE) | ((r_state == S_HOLD) & out_ready);
`else
    assign in_ready = (r_state == S_IDLE);
`endif

    assign w_accept  = in_valid & in_ready;
    assign out_valid = (r_state == S_HOLD);
    assign out_data  = r_d;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_d     <= '0;
            r_c     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_d     <= w_d_nxt;
            r_c     <= w_c_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_d_nxt     = r_d;
        w_c_nxt     = r_c;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_d_nxt     = in_data;
                    w_c_nxt     = w_k_eff;
                    w_state_nxt = (w_k_eff == '0) ? S_HOLD : S_RUN;
                end
            end
            S_RUN: begin
                w_d_nxt = w_half;
                w_c_nxt = r_c - 1'b1;
                if (r_c == SHW'(1)) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
                // Only reachable in the pipelined build; in_ready is low here otherwise.
                if (w_accept) begin
                    w_d_nxt     = in_data;
                    w_c_nxt     = w_k_eff;
                    w_state_nxt = (w_k_eff == '0) ? S_HOLD : S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_halve_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_halve_seq
// Brief    : Self-checking bench for halve_seq (q = 12289, MAX_SHIFT = 10).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_halve_seq;

    localparam int LOGQ = 14;
    localparam int Q    = 12289;
    localparam int SHW  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [LOGQ-1:0] in_data = '0;
    logic [SHW-1:0]  in_shift = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [LOGQ-1:0] out_data;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    halve_seq #(.LOGQ(LOGQ), .Q_VALUE(Q), .MAX_SHIFT(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LOGQ-1:0] x;
        logic [SHW-1:0]  k;
        logic [LOGQ-1:0] exp;
        int              lat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // x * 6145^k mod q, where 6145 is the inverse of 2 mod 12289.
    function automatic logic [LOGQ-1:0] ref_model(input int x, input int k);
        longint r = x;
        int kk = (k > 10) ? 10 : k;
        for (int i = 0; i < kk; i++) r = (r * 6145) % Q;
        return LOGQ'(r);
    endfunction

    task automatic run_one(input vec_t v, input int idx);
        int n;
        int lat;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        in_valid = 1'b1; in_data = v.x; in_shift = v.k; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk($sformatf("vec%0d latency", idx), lat, v.lat);
        chk($sformatf("vec%0d data", idx), out_data, v.exp);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        chk($sformatf("vec%0d drain", idx), out_valid, 0);
    endtask

    initial begin
        logic [LOGQ-1:0] exp_q[$];
        logic [LOGQ-1:0] exp_v;
        int sent;
        int recv;
        int cyc;
        int stale;
        bit presenting;

        vecs[0] = '{x: 14'd2,     k: 4'd1,  exp: 14'd1,     lat: 1};
        vecs[1] = '{x: 14'd1,     k: 4'd1,  exp: 14'd6145,  lat: 1};
        vecs[2] = '{x: 14'd12288, k: 4'd1,  exp: 14'd6144,  lat: 1};
        vecs[3] = '{x: 14'd12287, k: 4'd1,  exp: 14'd12288, lat: 1};
        vecs[4] = '{x: 14'd1,     k: 4'd2,  exp: 14'd9217,  lat: 2};
        vecs[5] = '{x: 14'd1024,  k: 4'd10, exp: 14'd1,     lat: 10};
        vecs[6] = '{x: 14'd0,     k: 4'd10, exp: 14'd0,     lat: 10};
        vecs[7] = '{x: 14'd777,   k: 4'd0,  exp: 14'd777,   lat: 0};
        vecs[8] = '{x: 14'd1024,  k: 4'd15, exp: 14'd1,     lat: 10};

        // Reset state
        #2;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset busy", busy, 0);
        chk("reset in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_one(vecs[i], i);

        // Reset in the middle of a RUN
        @(negedge clk);
        in_valid = 1'b1; in_data = 14'd1; in_shift = 4'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrun busy before rst", busy, 1);
        rst = 1'b1; #1;
        chk("midrun rst out_valid", out_valid, 0);
        chk("midrun rst out_data", out_data, 0);
        chk("midrun rst busy", busy, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0; #1;
        chk("midrun release in_ready", in_ready, 1);
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        chk("midrun no stale result", stale, 0);

        // Backpressure while holding a result
        @(negedge clk);
        in_valid = 1'b1; in_data = 14'd1; in_shift = 4'd1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = i[0]; in_data = 14'(100 + i); in_shift = 4'd0;
            #1;
            chk($sformatf("bp%0d out_valid", i), out_valid, 1);
            chk($sformatf("bp%0d out_data", i), out_data, 6145);
            chk($sformatf("bp%0d in_ready", i), in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp drain out_valid", out_valid, 0);
        chk("bp drain busy", busy, 0);

        // Random streaming with gaps on both sides
        sent = 0; recv = 0; cyc = 0; presenting = 0;
        while ((sent < 20 || recv < 20) && cyc < 2000) begin
            @(negedge clk);
            if (!presenting && sent < 20 && $urandom_range(0, 1) == 1) begin
                presenting = 1;
                in_data  = LOGQ'($urandom_range(0, Q - 1));
                in_shift = SHW'($urandom_range(0, 10));
            end
            in_valid  = presenting;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream unexpected result", 1, 0);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk($sformatf("stream result %0d", recv), out_data, exp_v);
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(int'(in_data), int'(in_shift)));
                sent++;
                presenting = 0;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("stream results received", recv, 20);

`ifdef HALVE_SEQ_PIPE_EN
        // k=0 back-to-back: one result per cycle
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; out_ready = 1'b1; in_shift = 4'd0;
            in_data = LOGQ'(500 + 3 * i);
            #1;
            chk($sformatf("pipe%0d in_ready", i), in_ready, 1);
            if (i > 0) begin
                chk($sformatf("pipe%0d out_valid", i), out_valid, 1);
                chk($sformatf("pipe%0d out_data", i), out_data, 500 + 3 * (i - 1));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
